// File: rtl/rob_pkg.sv
// Shared widths, constants and bus-slicing helpers for the reorder buffer.
// Imported by reorder_buffer_param and rob_wb_arbiter.
package rob_pkg;

    localparam int DEF_DEPTH  = 8;
    localparam int DEF_TAG_W  = 3;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 32;
    localparam int DEF_RD_W   = 5;
    localparam int DEF_NUM_WB = 2;

    // Sequential fall-through distance used to detect a mispredict.
    localparam int PC_STEP = 4;

    // LSB of channel ch inside a flattened per-channel bus of given width.
    function automatic int wb_lsb(input int ch, input int width);
        return ch * width;
    endfunction

endpackage

// File: rtl/rob_wb_arbiter.sv
// Per-entry writeback selector: picks the lowest-index channel hitting IDX.
// Ports: flattened wb_valid/tag/data/jpc in; hit, data, jpc out.
module rob_wb_arbiter
    import rob_pkg::*;
#(
    parameter int TAG_W  = DEF_TAG_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NUM_WB = DEF_NUM_WB,
    parameter int IDX    = 0
) (
    input  logic [NUM_WB-1:0]        wb_valid_i,
    input  logic [NUM_WB*TAG_W-1:0]  wb_tag_i,
    input  logic [NUM_WB*DATA_W-1:0] wb_data_i,
    input  logic [NUM_WB*ADDR_W-1:0] wb_jpc_i,
    output logic                     hit_o,
    output logic [DATA_W-1:0]        data_o,
    output logic [ADDR_W-1:0]        jpc_o
);

    localparam logic [TAG_W-1:0] MY_TAG = TAG_W'(IDX);

    // Scan from the highest channel down so the lowest index overrides.
    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        jpc_o  = '0;
        for (int i = NUM_WB - 1; i >= 0; i--) begin
            if (wb_valid_i[i] &&
                wb_tag_i[wb_lsb(i, TAG_W) +: TAG_W] == MY_TAG) begin
                hit_o  = 1'b1;
                data_o = wb_data_i[wb_lsb(i, DATA_W) +: DATA_W];
                jpc_o  = wb_jpc_i[wb_lsb(i, ADDR_W) +: ADDR_W];
            end
        end
    end

endmodule

// File: rtl/reorder_buffer_param.sv
// In-order-retire reorder buffer: dispatch in, NUM_WB writebacks, one commit
// per cycle, one-cycle flush with redirect PC when a mispredicted branch retires.
// Ports: disp_* (handshake + tag), wb_* (flattened), commit_*, flush*, count.
module reorder_buffer_param
    import rob_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int TAG_W  = DEF_TAG_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int RD_W   = DEF_RD_W,
    parameter int NUM_WB = DEF_NUM_WB
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     disp_valid,
    output logic                     disp_ready,
    input  logic [RD_W-1:0]          disp_rd,
    input  logic [ADDR_W-1:0]        disp_pc,
    input  logic                     disp_is_branch,
    input  logic                     disp_is_store,
    output logic [TAG_W-1:0]         disp_tag,
    input  logic [NUM_WB-1:0]        wb_valid,
    input  logic [NUM_WB*TAG_W-1:0]  wb_tag,
    input  logic [NUM_WB*DATA_W-1:0] wb_data,
    input  logic [NUM_WB*ADDR_W-1:0] wb_jpc,
    output logic                     commit_valid,
    output logic [TAG_W-1:0]         commit_tag,
    output logic [RD_W-1:0]          commit_rd,
    output logic [DATA_W-1:0]        commit_data,
    output logic                     commit_store,
    output logic                     flush,
    output logic [ADDR_W-1:0]        flush_pc,
    output logic [TAG_W:0]           count
);

    logic [TAG_W-1:0]  head_q, tail_q;
    logic [TAG_W:0]    count_q, count_d;
    logic [DEPTH-1:0]  busy_q, done_q, mp_q, br_q, st_q;
    logic [RD_W-1:0]   rd_q   [DEPTH];
    logic [ADDR_W-1:0] pc_q   [DEPTH];
    logic [ADDR_W-1:0] jpc_q  [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];

    logic              cv_q, cst_q, flush_q;
    logic [TAG_W-1:0]  ctag_q;
    logic [RD_W-1:0]   crd_q;
    logic [DATA_W-1:0] cdata_q;
    logic [ADDR_W-1:0] fpc_q;

    logic [DEPTH-1:0]  wb_hit, wb_en, mp_new;
    logic [DATA_W-1:0] wb_dat [DEPTH];
    logic [ADDR_W-1:0] wb_jp  [DEPTH];

    logic disp_fire, commit_fire, flush_now;

    for (genvar e = 0; e < DEPTH; e++) begin : g_arb
        rob_wb_arbiter #(
            .TAG_W  (TAG_W),
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W),
            .NUM_WB (NUM_WB),
            .IDX    (e)
        ) u_arb (
            .wb_valid_i (wb_valid),
            .wb_tag_i   (wb_tag),
            .wb_data_i  (wb_data),
            .wb_jpc_i   (wb_jpc),
            .hit_o      (wb_hit[e]),
            .data_o     (wb_dat[e]),
            .jpc_o      (wb_jp[e])
        );
    end

    // Only live, still-pending entries accept a result.
    always_comb begin
        wb_en  = '0;
        mp_new = '0;
        for (int e = 0; e < DEPTH; e++) begin
            wb_en[e]  = wb_hit[e] && busy_q[e] && !done_q[e];
            mp_new[e] = br_q[e] &&
                        (wb_jp[e] != pc_q[e] + ADDR_W'(PC_STEP));
        end
    end

    assign disp_ready  = (count_q != (TAG_W+1)'(DEPTH)) && !flush_q;
    assign disp_fire   = disp_valid && disp_ready;
    assign commit_fire = busy_q[head_q] && done_q[head_q];
    assign flush_now   = commit_fire && mp_q[head_q];
    assign count_d     = count_q + (TAG_W+1)'(disp_fire)
                                 - (TAG_W+1)'(commit_fire);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            busy_q  <= '0;
            done_q  <= '0;
            mp_q    <= '0;
            cv_q    <= 1'b0;
            ctag_q  <= '0;
            crd_q   <= '0;
            cdata_q <= '0;
            cst_q   <= 1'b0;
            flush_q <= 1'b0;
            fpc_q   <= '0;
        end else begin
            cv_q    <= commit_fire;
            flush_q <= flush_now;
            if (commit_fire) begin
                ctag_q  <= head_q;
                crd_q   <= rd_q[head_q];
                cdata_q <= data_q[head_q];
                cst_q   <= st_q[head_q];
            end
            if (flush_now) begin
                // Everything younger than the branch is wrong-path.
                fpc_q   <= jpc_q[head_q];
                busy_q  <= '0;
                done_q  <= '0;
                mp_q    <= '0;
                head_q  <= '0;
                tail_q  <= '0;
                count_q <= '0;
            end else begin
                for (int e = 0; e < DEPTH; e++) begin
                    if (wb_en[e]) begin
                        done_q[e] <= 1'b1;
                        mp_q[e]   <= mp_new[e];
                    end
                end
                if (commit_fire) begin
                    busy_q[head_q] <= 1'b0;
                    head_q         <= head_q + TAG_W'(1);
                end
                if (disp_fire) begin
                    busy_q[tail_q] <= 1'b1;
                    done_q[tail_q] <= 1'b0;
                    mp_q[tail_q]   <= 1'b0;
                    tail_q         <= tail_q + TAG_W'(1);
                end
                count_q <= count_d;
            end
        end
    end

    // Payload needs no reset: it is only observed through busy/done.
    always_ff @(posedge clk) begin
        for (int e = 0; e < DEPTH; e++) begin
            if (wb_en[e]) begin
                data_q[e] <= wb_dat[e];
                if (br_q[e]) begin
                    jpc_q[e] <= wb_jp[e];
                end
            end
        end
        if (disp_fire) begin
            rd_q[tail_q] <= disp_rd;
            pc_q[tail_q] <= disp_pc;
            br_q[tail_q] <= disp_is_branch;
            st_q[tail_q] <= disp_is_store;
        end
    end

    assign disp_tag     = tail_q;
    assign commit_valid = cv_q;
    assign commit_tag   = ctag_q;
    assign commit_rd    = crd_q;
    assign commit_data  = cdata_q;
    assign commit_store = cst_q;
    assign flush        = flush_q;
    assign flush_pc     = fpc_q;
    assign count        = count_q;

endmodule
